// File: rtl/ahb_pkg.sv
// Shared AHB definitions: bus widths, HTRANS/HRESP codes, return-path select and default-slave state.
package ahb_pkg;

    localparam int unsigned AHB_ADDR_BITS  = 32;
    localparam int unsigned AHB_DATA_BITS  = 32;
    localparam int unsigned AHB_TRANS_BITS = 2;
    localparam int unsigned AHB_RESP_BITS  = 2;

    localparam logic [AHB_RESP_BITS-1:0] AHB_RESP_OKAY  = 2'b00;
    localparam logic [AHB_RESP_BITS-1:0] AHB_RESP_ERROR = 2'b01;

    localparam logic [AHB_TRANS_BITS-1:0] AHB_TRANS_IDLE   = 2'b00;
    localparam logic [AHB_TRANS_BITS-1:0] AHB_TRANS_BUSY   = 2'b01;
    localparam logic [AHB_TRANS_BITS-1:0] AHB_TRANS_NONSEQ = 2'b10;
    localparam logic [AHB_TRANS_BITS-1:0] AHB_TRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        SEL_DEF = 2'd0,
        SEL_S1  = 2'd1,
        SEL_S2  = 2'd2,
        SEL_S3  = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response plus sticky
// capture of the first faulting address.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      hready_i,
    input  logic                      sel_def_i,
    input  logic [AHB_TRANS_BITS-1:0] htrans_i,
    input  logic [AHB_ADDR_BITS-1:0]  haddr_i,
    input  logic                      err_clr_i,
    output logic                      ready_o,
    output logic [AHB_RESP_BITS-1:0]  resp_o,
    output logic                      err_valid_o,
    output logic [AHB_ADDR_BITS-1:0]  err_addr_o
);

    ds_state_e                     state_q, state_d;
    logic                          ready_q, ready_d;
    logic [AHB_RESP_BITS-1:0]      resp_q, resp_d;
    logic                          err_valid_q, err_valid_d;
    logic [AHB_ADDR_BITS-1:0]      err_addr_q, err_addr_d;
    logic                          req;
    logic                          capture;

    assign req = hready_i && sel_def_i &&
                 ((htrans_i == AHB_TRANS_NONSEQ) || (htrans_i == AHB_TRANS_SEQ));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= DS_IDLE;
            ready_q     <= 1'b1;
            resp_q      <= AHB_RESP_OKAY;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            resp_q      <= resp_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Response outputs are registered from the next state so they track state_q exactly.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;

        unique case (state_q)
            DS_IDLE: if (req) begin
                state_d = DS_ERR1;
                capture = 1'b1;
            end
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: if (req) begin
                state_d = DS_ERR1;
                capture = 1'b1;
            end else begin
                state_d = DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase

        ready_d = (state_d != DS_ERR1);
        resp_d  = (state_d == DS_IDLE) ? AHB_RESP_OKAY : AHB_RESP_ERROR;

        // A capture coinciding with a clear takes the new address and keeps the flag set.
        if (err_clr_i) begin
            err_valid_d = 1'b0;
        end
        if (capture) begin
            err_valid_d = 1'b1;
            if (!err_valid_q || err_clr_i) begin
                err_addr_d = haddr_i;
            end
        end
    end

    assign ready_o     = ready_q;
    assign resp_o      = resp_q;
    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: rtl/ahb_s2m_decoder.sv
// AHB address decoder and slave-to-master return mux, with a built-in default
// slave answering unmapped transfers.
module ahb_s2m_decoder
    import ahb_pkg::*;
#(
    parameter logic [AHB_ADDR_BITS-1:0] S1_BASE = 32'h0000_0000,
    parameter logic [AHB_ADDR_BITS-1:0] S1_MASK = 32'hFFFF_0000,
    parameter logic [AHB_ADDR_BITS-1:0] S2_BASE = 32'h1000_0000,
    parameter logic [AHB_ADDR_BITS-1:0] S2_MASK = 32'hFFFF_0000,
    parameter logic [AHB_ADDR_BITS-1:0] S3_BASE = 32'h2000_0000,
    parameter logic [AHB_ADDR_BITS-1:0] S3_MASK = 32'hFFFF_0000
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [AHB_ADDR_BITS-1:0]  HADDR,
    input  logic [AHB_TRANS_BITS-1:0] HTRANS,
    output logic                      HSEL_S1,
    output logic                      HSEL_S2,
    output logic                      HSEL_S3,
    input  logic [AHB_DATA_BITS-1:0]  HRDATA_S1,
    input  logic [AHB_DATA_BITS-1:0]  HRDATA_S2,
    input  logic [AHB_DATA_BITS-1:0]  HRDATA_S3,
    input  logic                      HREADY_S1,
    input  logic                      HREADY_S2,
    input  logic                      HREADY_S3,
    input  logic [AHB_RESP_BITS-1:0]  HRESP_S1,
    input  logic [AHB_RESP_BITS-1:0]  HRESP_S2,
    input  logic [AHB_RESP_BITS-1:0]  HRESP_S3,
    output logic [AHB_DATA_BITS-1:0]  HRDATA,
    output logic                      HREADY,
    output logic [AHB_RESP_BITS-1:0]  HRESP,
    output logic                      ERR_VALID,
    output logic [AHB_ADDR_BITS-1:0]  ERR_ADDR,
    input  logic                      ERR_CLR
);

    sel_e                     sel_cur;
    sel_e                     sel_prev_q, sel_prev_d;
    logic                     ds_ready;
    logic [AHB_RESP_BITS-1:0] ds_resp;

    // Address decode with fixed priority S1 > S2 > S3 on overlapping windows.
    always_comb begin
        sel_cur = SEL_DEF;
        if ((HADDR & S1_MASK) == S1_BASE) begin
            sel_cur = SEL_S1;
        end else if ((HADDR & S2_MASK) == S2_BASE) begin
            sel_cur = SEL_S2;
        end else if ((HADDR & S3_MASK) == S3_BASE) begin
            sel_cur = SEL_S3;
        end
    end

    assign HSEL_S1 = (sel_cur == SEL_S1);
    assign HSEL_S2 = (sel_cur == SEL_S2);
    assign HSEL_S3 = (sel_cur == SEL_S3);

    assign sel_prev_d = HREADY ? sel_cur : sel_prev_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_prev_q <= SEL_DEF;
        end else begin
            sel_prev_q <= sel_prev_d;
        end
    end

    // Data-phase owner drives the shared response, including HREADY.
    always_comb begin
        HRDATA = '0;
        HREADY = ds_ready;
        HRESP  = ds_resp;
        unique case (sel_prev_q)
            SEL_S1: begin
                HRDATA = HRDATA_S1;
                HREADY = HREADY_S1;
                HRESP  = HRESP_S1;
            end
            SEL_S2: begin
                HRDATA = HRDATA_S2;
                HREADY = HREADY_S2;
                HRESP  = HRESP_S2;
            end
            SEL_S3: begin
                HRDATA = HRDATA_S3;
                HREADY = HREADY_S3;
                HRESP  = HRESP_S3;
            end
            default: ;
        endcase
    end

    ahb_default_slave u_default_slave (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .hready_i    (HREADY),
        .sel_def_i   (sel_cur == SEL_DEF),
        .htrans_i    (HTRANS),
        .haddr_i     (HADDR),
        .err_clr_i   (ERR_CLR),
        .ready_o     (ds_ready),
        .resp_o      (ds_resp),
        .err_valid_o (ERR_VALID),
        .err_addr_o  (ERR_ADDR)
    );

endmodule

// File: tb/tb_ahb_s2m_decoder.sv
// Directed bench for ahb_s2m_decoder: decode, pipelined wait, default-slave
// ERROR sequence, error capture/clear and asynchronous reset mid-error.
module tb_ahb_s2m_decoder;
    import ahb_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HSEL_S1, HSEL_S2, HSEL_S3;
    logic [31:0] HRDATA_S1, HRDATA_S2, HRDATA_S3;
    logic        HREADY_S1, HREADY_S2, HREADY_S3;
    logic [1:0]  HRESP_S1, HRESP_S2, HRESP_S3;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic        ERR_VALID;
    logic [31:0] ERR_ADDR;
    logic        ERR_CLR;

    int checks   = 0;
    int failures = 0;

    ahb_s2m_decoder dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSEL_S1   (HSEL_S1),
        .HSEL_S2   (HSEL_S2),
        .HSEL_S3   (HSEL_S3),
        .HRDATA_S1 (HRDATA_S1),
        .HRDATA_S2 (HRDATA_S2),
        .HRDATA_S3 (HRDATA_S3),
        .HREADY_S1 (HREADY_S1),
        .HREADY_S2 (HREADY_S2),
        .HREADY_S3 (HREADY_S3),
        .HRESP_S1  (HRESP_S1),
        .HRESP_S2  (HRESP_S2),
        .HRESP_S3  (HRESP_S3),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .ERR_VALID (ERR_VALID),
        .ERR_ADDR  (ERR_ADDR),
        .ERR_CLR   (ERR_CLR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven 1 time unit after the edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic resp_chk(input string tag, input logic rdy, input logic [1:0] rsp);
        check({tag, "_hready"}, 32'(HREADY), 32'(rdy));
        check({tag, "_hresp"},  32'(HRESP),  32'(rsp));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn   = 1'b0;
        HADDR     = 32'h3000_0000;
        HTRANS    = AHB_TRANS_IDLE;
        HRDATA_S1 = 32'h1111_1111;
        HRDATA_S2 = 32'h2222_2222;
        HRDATA_S3 = 32'h3333_3333;
        HREADY_S1 = 1'b1;
        HREADY_S2 = 1'b1;
        HREADY_S3 = 1'b1;
        HRESP_S1  = AHB_RESP_OKAY;
        HRESP_S2  = AHB_RESP_OKAY;
        HRESP_S3  = AHB_RESP_OKAY;
        ERR_CLR   = 1'b0;

        // Reset values
        repeat (2) tick();
        #1;
        resp_chk("rst", 1'b1, 2'b00);
        check("rst_hrdata",   HRDATA, 32'h0);
        check("rst_errvalid", 32'(ERR_VALID), 32'h0);
        check("rst_erraddr",  ERR_ADDR, 32'h0);
        check("rst_hsel",     32'({HSEL_S1, HSEL_S2, HSEL_S3}), 32'h0);
        HRESETn = 1'b1;
        tick(); #1;
        resp_chk("rel", 1'b1, 2'b00);
        check("rel_hrdata", HRDATA, 32'h0);
        check("rel_errvalid", 32'(ERR_VALID), 32'h0);

        // NONSEQ read from S2
        HADDR = 32'h1000_0010; HTRANS = AHB_TRANS_NONSEQ; HRDATA_S2 = 32'hDEAD_BEEF;
        #1;
        check("s2_hsel", 32'({HSEL_S1, HSEL_S2, HSEL_S3}), 32'b010);
        tick();
        HADDR = 32'h0000_0100; HTRANS = AHB_TRANS_NONSEQ;
        #1;
        check("s2_hrdata", HRDATA, 32'hDEAD_BEEF);
        resp_chk("s2", 1'b1, 2'b00);
        check("s1_hsel", 32'({HSEL_S1, HSEL_S2, HSEL_S3}), 32'b100);

        // S1 data phase stalls three cycles while S3 address phase waits
        tick();
        HADDR = 32'h2000_0004; HTRANS = AHB_TRANS_NONSEQ; HREADY_S1 = 1'b0;
        #1;
        check("s3_hsel", 32'({HSEL_S1, HSEL_S2, HSEL_S3}), 32'b001);
        check("stall1_hready", 32'(HREADY), 32'h0);
        check("stall1_hrdata", HRDATA, 32'h1111_1111);
        tick(); #1;
        check("stall2_hready", 32'(HREADY), 32'h0);
        check("stall2_hrdata", HRDATA, 32'h1111_1111);
        tick(); #1;
        check("stall3_hready", 32'(HREADY), 32'h0);
        tick();
        HREADY_S1 = 1'b1;
        #1;
        check("s1_done_hready", 32'(HREADY), 32'h1);
        check("s1_done_hrdata", HRDATA, 32'h1111_1111);
        tick();
        HTRANS = AHB_TRANS_IDLE; HADDR = 32'h5000_0000;
        #1;
        check("s3_hrdata", HRDATA, 32'h3333_3333);
        resp_chk("s3", 1'b1, 2'b00);

        // IDLE to unmapped address: zero-wait OKAY, no error
        tick(); #1;
        resp_chk("idle_unmapped", 1'b1, 2'b00);
        check("idle_unmapped_errvalid", 32'(ERR_VALID), 32'h0);

        // Single unmapped NONSEQ
        HTRANS = AHB_TRANS_NONSEQ; HADDR = 32'h5000_0000;
        #1;
        check("unmapped_hsel", 32'({HSEL_S1, HSEL_S2, HSEL_S3}), 32'h0);
        tick();
        HTRANS = AHB_TRANS_IDLE; HADDR = 32'h0000_0000;
        #1;
        resp_chk("err1", 1'b0, 2'b01);
        check("err1_errvalid", 32'(ERR_VALID), 32'h1);
        check("err1_erraddr",  ERR_ADDR, 32'h5000_0000);
        tick(); #1;
        resp_chk("err2", 1'b1, 2'b01);
        check("err2_hrdata", HRDATA, 32'h0);
        tick();
        ERR_CLR = 1'b1;
        #1;
        resp_chk("after_err", 1'b1, 2'b00);
        tick();
        ERR_CLR = 1'b0;
        #1;
        check("clr_errvalid", 32'(ERR_VALID), 32'h0);

        // Back-to-back unmapped transfers
        HTRANS = AHB_TRANS_NONSEQ; HADDR = 32'h5000_0000;
        tick();
        HADDR = 32'h6000_0000;
        #1;
        resp_chk("b2b_a1", 1'b0, 2'b01);
        tick(); #1;
        resp_chk("b2b_a2", 1'b1, 2'b01);
        tick();
        HTRANS = AHB_TRANS_IDLE; HADDR = 32'h0000_0000;
        #1;
        resp_chk("b2b_b1", 1'b0, 2'b01);
        check("b2b_erraddr", ERR_ADDR, 32'h5000_0000);
        tick(); #1;
        resp_chk("b2b_b2", 1'b1, 2'b01);
        tick();
        ERR_CLR = 1'b1;
        #1;
        resp_chk("b2b_done", 1'b1, 2'b00);
        tick();
        ERR_CLR = 1'b0;
        #1;
        check("b2b_clr_errvalid", 32'(ERR_VALID), 32'h0);

        // Clear coinciding with a new capture: capture wins with the new address
        HTRANS = AHB_TRANS_NONSEQ; HADDR = 32'h5000_0000;
        tick();
        HTRANS = AHB_TRANS_IDLE; HADDR = 32'h0000_0000;
        tick();
        HTRANS = AHB_TRANS_NONSEQ; HADDR = 32'h7000_0000; ERR_CLR = 1'b1;
        tick();
        HTRANS = AHB_TRANS_IDLE; HADDR = 32'h0000_0000; ERR_CLR = 1'b0;
        #1;
        resp_chk("coinc_err1", 1'b0, 2'b01);
        check("coinc_errvalid", 32'(ERR_VALID), 32'h1);
        check("coinc_erraddr",  ERR_ADDR, 32'h7000_0000);
        tick(); tick();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;

        // Asynchronous reset during DS_ERR1
        HTRANS = AHB_TRANS_NONSEQ; HADDR = 32'h5000_0000;
        tick();
        HTRANS = AHB_TRANS_IDLE;
        #1;
        resp_chk("pre_rst_err1", 1'b0, 2'b01);
        HRESETn = 1'b0;
        #1;
        resp_chk("async_rst", 1'b1, 2'b00);
        check("async_rst_errvalid", 32'(ERR_VALID), 32'h0);
        tick(); tick();
        HRESETn = 1'b1;
        #1;
        resp_chk("post_rst0", 1'b1, 2'b00);
        tick(); #1;
        resp_chk("post_rst1", 1'b1, 2'b00);
        check("post_rst_errvalid", 32'(ERR_VALID), 32'h0);
        tick(); #1;
        resp_chk("post_rst2", 1'b1, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
